// File: rtl/vga_pkg.sv
// Shared VGA definitions: lock FSM states, default 1024x768 timing, constant log2 helper.
package vga_pkg;

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} lock_state_e;

    localparam int unsigned H_ACTIVE_DEF = 1024;
    localparam int unsigned H_FRONT_DEF  = 24;
    localparam int unsigned H_SYNC_DEF   = 136;
    localparam int unsigned H_BACK_DEF   = 144;
    localparam int unsigned H_TOTAL_DEF  = 1328;
    localparam int unsigned V_ACTIVE_DEF = 768;
    localparam int unsigned V_FRONT_DEF  = 3;
    localparam int unsigned V_SYNC_DEF   = 6;
    localparam int unsigned V_BACK_DEF   = 29;
    localparam int unsigned V_TOTAL_DEF  = 806;

    // Ceiling log2, never less than 1 so it can size a bus directly.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return (result == 0) ? 1 : result;
    endfunction

endpackage

// File: rtl/vga_edge_det.sv
// Registers one sync input and flags its rising and falling edges against the previous sample.
module vga_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic rise,
    output logic fall
);

    logic sync_q;
    logic sync_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_q    <= sync_in;
            sync_prev <= sync_q;
        end
    end

    assign rise = sync_q & ~sync_prev;
    assign fall = ~sync_q & sync_prev;

endmodule

// File: rtl/vga_sync_decoder.sv
// VGA sink: recovers pixel coordinates from hs/vs, measures timing and gates output on lock.
// Optional hs watchdog enabled by defining VGA_SYNC_DECODER_WATCHDOG_EN.
module vga_sync_decoder
    import vga_pkg::*;
#(
    parameter int unsigned COLOR_DEPTH = 8,
    parameter int unsigned VGA_WIDTH   = H_ACTIVE_DEF,
    parameter int unsigned VGA_HEIGHT  = V_ACTIVE_DEF,
    parameter int unsigned H_BACK_CNT  = H_BACK_DEF,
    parameter int unsigned V_BACK_CNT  = V_BACK_DEF,
    parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
    parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              vga_hs,
    input  logic                              vga_vs,
    input  logic [COLOR_DEPTH-1:0]            vga_r_in,
    input  logic [COLOR_DEPTH-1:0]            vga_g_in,
    input  logic [COLOR_DEPTH-1:0]            vga_b_in,
    output logic [COLOR_DEPTH-1:0]            pix_r,
    output logic [COLOR_DEPTH-1:0]            pix_g,
    output logic [COLOR_DEPTH-1:0]            pix_b,
    output logic                              pix_valid,
    output logic [clog2(VGA_WIDTH)-1:0]       pix_x,
    output logic [clog2(VGA_HEIGHT)-1:0]      pix_y,
    output logic                              frame_start,
    output logic                              locked,
    output logic [clog2(2*H_TOTAL)-1:0]       meas_h_total,
    output logic [clog2(2*V_TOTAL)-1:0]       meas_v_total,
    output logic [7:0]                        err_cnt
);

    localparam int unsigned XW = clog2(VGA_WIDTH);
    localparam int unsigned YW = clog2(VGA_HEIGHT);
    localparam int unsigned HW = clog2(2 * H_TOTAL);
    localparam int unsigned VW = clog2(2 * V_TOTAL);
    localparam int unsigned GW = clog2(LOCK_FRAMES + 1);

    localparam logic [HW-1:0] H_MAX    = '1;
    localparam logic [VW-1:0] V_MAX    = '1;
    localparam logic [HW-1:0] H_ACT_LO = HW'(H_BACK_CNT);
    localparam logic [HW-1:0] H_ACT_HI = HW'(H_BACK_CNT + VGA_WIDTH);
    localparam logic [VW-1:0] V_ACT_LO = VW'(V_BACK_CNT);
    localparam logic [VW-1:0] V_ACT_HI = VW'(V_BACK_CNT + VGA_HEIGHT);
    localparam logic [HW-1:0] H_TOT    = HW'(H_TOTAL);
    localparam logic [VW-1:0] V_TOT    = VW'(V_TOTAL);
    localparam logic [GW-1:0] GOOD_END = GW'(LOCK_FRAMES - 1);

    logic                   hs_rise, hs_fall, vs_rise, vs_fall;
    logic [COLOR_DEPTH-1:0] r_q, g_q, b_q;
    logic [HW-1:0]          h_pos_q, h_cur, h_cnt_q, h_cnt_d, meas_h_d;
    logic [VW-1:0]          v_pos_q, v_cur, v_cnt_q, v_cnt_d, v_inc, meas_v_d;
    logic                   v_pend_q, v_pend_d;
    lock_state_e            state_q, state_d;
    logic [GW-1:0]          good_q, good_d;
    logic                   bad_q, bad_d;
    logic                   h_mis, v_mis, err_inc, valid_d;
    logic [7:0]             err_d;

    vga_edge_det u_hs_edge (.clk(clk), .rst(rst), .sync_in(vga_hs), .rise(hs_rise), .fall(hs_fall));
    vga_edge_det u_vs_edge (.clk(clk), .rst(rst), .sync_in(vga_vs), .rise(vs_rise), .fall(vs_fall));

`ifdef VGA_SYNC_DECODER_WATCHDOG_EN
    localparam int unsigned   WW       = clog2(2 * H_TOTAL + 1);
    localparam logic [WW-1:0] WD_LIMIT = WW'(2 * H_TOTAL);
    logic [WW-1:0] wd_q, wd_d;
    logic          wd_timeout;

    assign wd_timeout = (wd_q == WD_LIMIT);
    assign wd_d       = hs_rise ? '0 : (wd_timeout ? wd_q : wd_q + 1'b1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wd_q <= '0;
        else     wd_q <= wd_d;
    end
`endif

    // h_cur/v_cur are the positions of the sample currently held in r_q/g_q/b_q.
    always_comb begin
        h_cur = h_pos_q;
        if (hs_fall)               h_cur = '0;
        else if (h_pos_q != H_MAX) h_cur = h_pos_q + 1'b1;

        v_cur    = v_pos_q;
        v_pend_d = v_pend_q | vs_fall;
        if (hs_fall) begin
            if (v_pend_q | vs_fall) begin
                v_cur    = '0;
                v_pend_d = 1'b0;
            end else if (v_pos_q != V_MAX) begin
                v_cur = v_pos_q + 1'b1;
            end
        end
    end

    always_comb begin
        h_cnt_d  = (h_cnt_q == H_MAX) ? h_cnt_q : h_cnt_q + 1'b1;
        meas_h_d = meas_h_total;
        if (hs_rise) begin
            meas_h_d = h_cnt_q;
            h_cnt_d  = HW'(1);
        end
        // A fall coincident with the vs rise closes the frame being measured.
        v_inc    = (hs_fall && v_cnt_q != V_MAX) ? v_cnt_q + 1'b1 : v_cnt_q;
        v_cnt_d  = v_inc;
        meas_v_d = meas_v_total;
        if (vs_rise) begin
            meas_v_d = v_inc;
            v_cnt_d  = '0;
        end
        h_mis = hs_rise & (h_cnt_q != H_TOT);
        v_mis = vs_rise & (v_inc != V_TOT);
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q | h_mis;
        err_inc = 1'b0;
        unique case (state_q)
            SEARCH: begin
                if (vs_rise) begin
                    state_d = TRACK;
                    good_d  = '0;
                    bad_d   = 1'b0;
                end
            end
            TRACK: begin
                if (vs_rise) begin
                    bad_d = 1'b0;
                    if (bad_q | h_mis | v_mis) begin
                        good_d = '0;
                    end else if (good_q == GOOD_END) begin
                        state_d = LOCKED;
                        good_d  = '0;
                    end else begin
                        good_d = good_q + 1'b1;
                    end
                end
            end
            LOCKED: begin
                if (h_mis | v_mis) begin
                    state_d = SEARCH;
                    err_inc = 1'b1;
                end
            end
            default: state_d = SEARCH;
        endcase
`ifdef VGA_SYNC_DECODER_WATCHDOG_EN
        if (wd_timeout) begin
            state_d = SEARCH;
            good_d  = '0;
            err_inc = (state_q == LOCKED);
        end
`endif
        err_d = (err_inc && err_cnt != 8'hFF) ? err_cnt + 1'b1 : err_cnt;
    end

    // Gate on the next state so pixels stop in the same cycle lock is lost.
    assign valid_d = (state_d == LOCKED) && (h_cur >= H_ACT_LO) && (h_cur < H_ACT_HI)
                     && (v_cur >= V_ACT_LO) && (v_cur < V_ACT_HI);
    assign locked  = (state_q == LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
            h_pos_q      <= '0;
            v_pos_q      <= '0;
            v_pend_q     <= 1'b0;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            meas_h_total <= '0;
            meas_v_total <= '0;
            state_q      <= SEARCH;
            good_q       <= '0;
            bad_q        <= 1'b0;
            err_cnt      <= '0;
            pix_r        <= '0;
            pix_g        <= '0;
            pix_b        <= '0;
            pix_valid    <= 1'b0;
            pix_x        <= '0;
            pix_y        <= '0;
            frame_start  <= 1'b0;
        end else begin
            r_q          <= vga_r_in;
            g_q          <= vga_g_in;
            b_q          <= vga_b_in;
            h_pos_q      <= h_cur;
            v_pos_q      <= v_cur;
            v_pend_q     <= v_pend_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            meas_h_total <= meas_h_d;
            meas_v_total <= meas_v_d;
            state_q      <= state_d;
            good_q       <= good_d;
            bad_q        <= bad_d;
            err_cnt      <= err_d;
            pix_r        <= valid_d ? r_q : '0;
            pix_g        <= valid_d ? g_q : '0;
            pix_b        <= valid_d ? b_q : '0;
            pix_valid    <= valid_d;
            pix_x        <= valid_d ? XW'(h_cur - H_ACT_LO) : '0;
            pix_y        <= valid_d ? YW'(v_cur - V_ACT_LO) : '0;
            frame_start  <= valid_d && (h_cur == H_ACT_LO) && (v_cur == V_ACT_LO);
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down 8x4 raster (16 cycles x 10 lines).
module tb_vga_sync_decoder;

    localparam int unsigned CD = 8, W = 8, H = 4, HB = 3, VB = 2;
    localparam int unsigned HT = 16, VT = 10, HSYNC = 2, VSYNC = 2, LF = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        vga_hs, vga_vs;
    logic [7:0]  vga_r_in, vga_g_in, vga_b_in;
    logic [7:0]  pix_r, pix_g, pix_b;
    logic        pix_valid, frame_start, locked;
    logic [2:0]  pix_x;
    logic [1:0]  pix_y;
    logic [4:0]  meas_h_total, meas_v_total;
    logic [7:0]  err_cnt;

    typedef struct packed {
        logic       chk;
        logic       valid;
        logic [2:0] x;
        logic [1:0] y;
        logic [7:0] r, g, b;
        logic       fs;
    } exp_t;

    exp_t pipe0, pipe1;
    logic pix_chk;
    int   checks = 0, errors = 0;
    int   vcount = 0, fscount = 0;

    vga_sync_decoder #(
        .COLOR_DEPTH(CD), .VGA_WIDTH(W), .VGA_HEIGHT(H), .H_BACK_CNT(HB), .V_BACK_CNT(VB),
        .H_TOTAL(HT), .V_TOTAL(VT), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst(rst), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_r_in(vga_r_in), .vga_g_in(vga_g_in), .vga_b_in(vga_b_in),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start), .locked(locked),
        .meas_h_total(meas_h_total), .meas_v_total(meas_v_total), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Called at a negedge: outputs now reflect the input driven two calls earlier.
    task automatic step(input logic hs, input logic vs, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input exp_t e);
        if (pix_valid) vcount++;
        if (frame_start) fscount++;
        if (pipe1.chk) begin
            checks++;
            if ({pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, frame_start} !==
                {pipe1.valid, pipe1.x, pipe1.y, pipe1.r, pipe1.g, pipe1.b, pipe1.fs}) begin
                errors++;
                $display("FAIL pixel: got v=%0b x=%0d y=%0d rgb=%h/%h/%h fs=%0b, expected v=%0b x=%0d y=%0d rgb=%h/%h/%h fs=%0b",
                         pix_valid, pix_x, pix_y, pix_r, pix_g, pix_b, frame_start,
                         pipe1.valid, pipe1.x, pipe1.y, pipe1.r, pipe1.g, pipe1.b, pipe1.fs);
            end
        end
        pipe1    = pipe0;
        pipe0    = e;
        vga_hs   = hs;
        vga_vs   = vs;
        vga_r_in = r;
        vga_g_in = g;
        vga_b_in = b;
        @(negedge clk);
    endtask

    // Line of 'len' cycles: hs low from cycle 0, high for the last HSYNC cycles.
    task automatic drive_span(input int lc, input int len, input int first, input int last);
        for (int hc = first; hc <= last; hc++) begin
            logic       act;
            logic [7:0] r, g, b;
            exp_t       e;
            act     = (hc >= HB) && (hc < HB + W) && (lc >= VB) && (lc < VB + H);
            r       = 8'(hc);
            g       = 8'(lc);
            b       = 8'(hc ^ (lc << 4));
            e.chk   = pix_chk;
            e.valid = act;
            e.x     = act ? 3'(hc - HB) : 3'd0;
            e.y     = act ? 2'(lc - VB) : 2'd0;
            e.r     = act ? r : 8'd0;
            e.g     = act ? g : 8'd0;
            e.b     = act ? b : 8'd0;
            e.fs    = act && (hc == HB) && (lc == VB);
            step(hc >= len - HSYNC, lc >= VT - VSYNC, r, g, b, e);
        end
    endtask

    task automatic drive_line(input int lc, input int len);
        drive_span(lc, len, 0, len - 1);
    endtask

    task automatic drive_frame();
        for (int lc = 0; lc < VT; lc++) drive_line(lc, HT);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b expected 0", locked); end
        checks++; if ({pix_valid, frame_start} !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b expected 00", {pix_valid, frame_start}); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err: got %0d expected 0", err_cnt); end
        checks++; if ({meas_h_total, meas_v_total} !== 10'd0) begin errors++; $display("FAIL reset_meas: got %0d/%0d expected 0/0", meas_h_total, meas_v_total); end
        checks++; if ({pix_r, pix_g, pix_b, pix_x, pix_y} !== 29'd0) begin errors++; $display("FAIL reset_pix: got %h expected 0", {pix_r, pix_g, pix_b, pix_x, pix_y}); end
        rst = 1'b0;
    endtask

    task automatic test_lock();
        drive_frame();
        drive_frame();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %0b expected 0", locked); end
        checks++; if (meas_v_total !== 5'd10) begin errors++; $display("FAIL lock_meas_v1: got %0d expected 10", meas_v_total); end
        for (int lc = 0; lc < 8; lc++) drive_line(lc, HT);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_before_vs3: got %0b expected 0", locked); end
        drive_line(8, HT);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_at_vs3: got %0b expected 1", locked); end
        checks++; if (meas_h_total !== 5'd16) begin errors++; $display("FAIL lock_meas_h: got %0d expected 16", meas_h_total); end
        checks++; if (meas_v_total !== 5'd10) begin errors++; $display("FAIL lock_meas_v: got %0d expected 10", meas_v_total); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL lock_err: got %0d expected 0", err_cnt); end
        drive_line(9, HT);
    endtask

    task automatic test_pixels();
        vcount  = 0;
        fscount = 0;
        pix_chk = 1'b1;
        drive_frame();
        pix_chk = 1'b0;
        checks++; if (vcount != W * H) begin errors++; $display("FAIL pix_count: got %0d expected %0d", vcount, W * H); end
        checks++; if (fscount != 1) begin errors++; $display("FAIL frame_start_count: got %0d expected 1", fscount); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL pix_locked: got %0b expected 1", locked); end
    endtask

    task automatic test_long_line();
        vcount = 0;
        for (int lc = 0; lc < 6; lc++) drive_line(lc, HT);
        drive_line(6, HT + 1);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL long_unlock: got %0b expected 0", locked); end
        checks++; if (err_cnt !== 8'd1) begin errors++; $display("FAIL long_err: got %0d expected 1", err_cnt); end
        checks++; if (meas_h_total !== 5'd17) begin errors++; $display("FAIL long_meas_h: got %0d expected 17", meas_h_total); end
        for (int lc = 7; lc < VT; lc++) drive_line(lc, HT);
        checks++; if (vcount != W * H) begin errors++; $display("FAIL long_count: got %0d expected %0d", vcount, W * H); end
        vcount = 0;
        drive_frame();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL long_relock_early: got %0b expected 0", locked); end
        checks++; if (vcount != 0) begin errors++; $display("FAIL long_unlocked_count: got %0d expected 0", vcount); end
        for (int lc = 0; lc < 9; lc++) drive_line(lc, HT);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL long_relock: got %0b expected 1", locked); end
        drive_line(9, HT);
    endtask

    task automatic test_short_frame();
        vcount = 0;
        for (int lc = 1; lc < 8; lc++) drive_line(lc, HT);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL short_pre: got %0b expected 1", locked); end
        drive_line(8, HT);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL short_unlock: got %0b expected 0", locked); end
        checks++; if (err_cnt !== 8'd2) begin errors++; $display("FAIL short_err: got %0d expected 2", err_cnt); end
        checks++; if (meas_v_total !== 5'd9) begin errors++; $display("FAIL short_meas_v: got %0d expected 9", meas_v_total); end
        checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL short_valid: got %0b expected 0", pix_valid); end
        drive_line(9, HT);
        checks++; if (vcount != W * H) begin errors++; $display("FAIL short_count: got %0d expected %0d", vcount, W * H); end
        repeat (3) drive_frame();
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL short_relock: got %0b expected 1", locked); end
    endtask

    task automatic test_reset_mid();
        for (int lc = 0; lc < 3; lc++) drive_line(lc, HT);
        drive_span(3, HT, 0, 7);
        checks++; if ({pix_valid, pix_x} !== {1'b1, 3'd3}) begin errors++; $display("FAIL mid_pre: got v=%0b x=%0d expected v=1 x=3", pix_valid, pix_x); end
        rst = 1'b1;
        #1;
        checks++; if ({locked, pix_valid, frame_start} !== 3'b000) begin errors++; $display("FAIL mid_async: got %b expected 000", {locked, pix_valid, frame_start}); end
        checks++; if ({err_cnt, meas_h_total, meas_v_total} !== 18'd0) begin errors++; $display("FAIL mid_async_cnt: got err=%0d h=%0d v=%0d expected 0", err_cnt, meas_h_total, meas_v_total); end
        checks++; if ({pix_r, pix_g, pix_b, pix_x, pix_y} !== 29'd0) begin errors++; $display("FAIL mid_async_pix: got %h expected 0", {pix_r, pix_g, pix_b, pix_x, pix_y}); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int lc = 4; lc < VT; lc++) drive_line(lc, HT);
        drive_frame();
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL mid_relock_early: got %0b expected 0", locked); end
        for (int lc = 0; lc < 9; lc++) drive_line(lc, HT);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mid_relock: got %0b expected 1", locked); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL mid_err: got %0d expected 0", err_cnt); end
        drive_line(9, HT);
    endtask

    task automatic test_stall();
        for (int lc = 0; lc < 6; lc++) drive_line(lc, HT);
        drive_span(6, 3 * HT, 0, 3 * HT - HSYNC - 1);
`ifdef VGA_SYNC_DECODER_WATCHDOG_EN
        checks++; if ({locked, err_cnt} !== {1'b0, 8'd1}) begin errors++; $display("FAIL stall_wd: got locked=%0b err=%0d expected 0/1", locked, err_cnt); end
        drive_span(6, 3 * HT, 3 * HT - HSYNC, 3 * HT - 1);
        checks++; if ({locked, err_cnt} !== {1'b0, 8'd1}) begin errors++; $display("FAIL stall_wd_post: got locked=%0b err=%0d expected 0/1", locked, err_cnt); end
`else
        checks++; if ({locked, err_cnt} !== {1'b1, 8'd0}) begin errors++; $display("FAIL stall_hold: got locked=%0b err=%0d expected 1/0", locked, err_cnt); end
        drive_span(6, 3 * HT, 3 * HT - HSYNC, 3 * HT - 1);
        checks++; if ({locked, err_cnt} !== {1'b0, 8'd1}) begin errors++; $display("FAIL stall_unlock: got locked=%0b err=%0d expected 0/1", locked, err_cnt); end
        checks++; if (meas_h_total !== 5'd31) begin errors++; $display("FAIL stall_meas_sat: got %0d expected 31", meas_h_total); end
`endif
        for (int lc = 7; lc < VT; lc++) drive_line(lc, HT);
    endtask

    initial begin
        vga_hs   = 1'b0;
        vga_vs   = 1'b0;
        vga_r_in = 8'd0;
        vga_g_in = 8'd0;
        vga_b_in = 8'd0;
        pix_chk  = 1'b0;
        pipe0    = '0;
        pipe1    = '0;
        test_reset();
        test_lock();
        test_pixels();
        test_long_line();
        test_short_frame();
        test_reset_mid();
        test_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
